// File: rtl/reg_cpu_pkg.sv
// Shared types for the reg_cpu register bank: FSM states, per-register access
// kinds and the helper that maps the RO/W1C masks onto an access kind.
package reg_cpu_pkg;

  localparam int unsigned MAX_REGS = 256;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } acc_e;

  // Read-only takes precedence when a register appears in both masks.
  function automatic acc_e acc_type(input logic [MAX_REGS-1:0] ro_mask,
                                    input logic [MAX_REGS-1:0] w1c_mask,
                                    input int unsigned         i);
    if (ro_mask[i]) return ACC_RO;
    if (w1c_mask[i]) return ACC_W1C;
    return ACC_RW;
  endfunction

endpackage

// File: rtl/reg_cpu_addr_decode.sv
// Byte-address decode for the register bank: strips the base, checks stride
// alignment and range, and returns the register index.
module reg_cpu_addr_decode
  import reg_cpu_pkg::*;
#(
  parameter int unsigned     AW          = 32,
  parameter int unsigned     NUM_REGS    = 16,
  parameter logic [AW-1:0]   BASE_ADDR   = '0,
  parameter int unsigned     ADDR_STRIDE = 4,
  parameter int unsigned     IW          = 4
) (
  input  logic [AW-1:0] addr,
  output logic          hit_c,
  output logic [IW-1:0] index_c
);

  localparam int unsigned SHIFT = $clog2(ADDR_STRIDE);

  logic [AW-1:0] offset;
  logic [AW-1:0] quotient;
  logic          aligned;

  // Addresses below the base wrap to huge offsets and fall out of range.
  always_comb begin
    offset   = addr - BASE_ADDR;
    aligned  = (offset & AW'(ADDR_STRIDE - 1)) == '0;
    quotient = offset >> SHIFT;
    hit_c    = aligned && (quotient < AW'(NUM_REGS));
    index_c  = quotient[IW-1:0];
  end

endmodule

// File: rtl/reg_cpu_regbank.sv
// Parametrised reg_cpu bus slave: NUM_REGS registers with RW/RO/W1C access,
// programmable ack latency, decode-miss and we/re collision error reporting.
module reg_cpu_regbank
  import reg_cpu_pkg::*;
#(
  parameter int unsigned         DW          = 32,
  parameter int unsigned         AW          = 32,
  parameter int unsigned         NUM_REGS    = 16,
  parameter logic [AW-1:0]       BASE_ADDR   = '0,
  parameter int unsigned         ADDR_STRIDE = 4,
  parameter int unsigned         WR_LATENCY  = 1,
  parameter int unsigned         RD_LATENCY  = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK    = '0,
  parameter logic [DW-1:0]       RESET_VAL   = '0,
  parameter logic [31:0]         MISS_RD_VAL = 32'hDEAD_BEEF
) (
  input  logic                   reg_cpu_clk,
  input  logic                   rst_n,
  input  logic                   reg_cpu_cs,
  input  logic [AW-1:0]          reg_cpu_addr,
  input  logic [DW-1:0]          reg_cpu_wr_data,
  input  logic                   reg_cpu_we,
  input  logic                   reg_cpu_re,
  output logic [DW-1:0]          reg_cpu_rd_data,
  output logic                   reg_cpu_wack,
  output logic                   reg_cpu_rdv,
  output logic                   reg_cpu_err,
  input  logic [NUM_REGS*DW-1:0] hw_ro_in,
  input  logic [NUM_REGS*DW-1:0] hw_set,
  output logic [NUM_REGS*DW-1:0] reg_q,
  output logic                   irq
);

  localparam int unsigned      IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [DW-1:0]    MISS_VAL = DW'(MISS_RD_VAL);
  localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WR_LATENCY - 1);
  localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(RD_LATENCY - 1);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             req_c;
  logic             accept_c;
  logic             fire_c;
  logic             wr_commit_c;

  logic             dec_hit_c;
  logic [IW-1:0]    dec_idx_c;

  logic             lat_we;
  logic             lat_err;
  logic             lat_hit;
  logic [IW-1:0]    lat_idx;
  logic [DW-1:0]    lat_wdata;

  logic [NUM_REGS-1:0][DW-1:0] q_all;
  logic [NUM_REGS-1:0][DW-1:0] w1c_view;

  reg_cpu_addr_decode #(
    .AW          (AW),
    .NUM_REGS    (NUM_REGS),
    .BASE_ADDR   (BASE_ADDR),
    .ADDR_STRIDE (ADDR_STRIDE),
    .IW          (IW)
  ) u_decode (
    .addr    (reg_cpu_addr),
    .hit_c   (dec_hit_c),
    .index_c (dec_idx_c)
  );

  assign req_c       = reg_cpu_cs & (reg_cpu_we | reg_cpu_re);
  assign wr_commit_c = fire_c & lat_we & lat_hit;

  // State and latency counter
  always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The cycle spent in ACK is the one whose closing edge commits and pulses.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    fire_c     = 1'b0;
    case (state)
      IDLE: begin
        if (req_c) begin
          accept_c   = 1'b1;
          cnt_next   = reg_cpu_we ? WR_CNT : RD_CNT;
          state_next = (cnt_next == '0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt_next == '0) state_next = ACK;
      end
      ACK: begin
        fire_c     = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (!req_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture at acceptance; a we&re collision is treated as a write.
  always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_hit   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (accept_c) begin
      lat_we    <= reg_cpu_we;
      lat_err   <= ~dec_hit_c | (reg_cpu_we & reg_cpu_re);
      lat_hit   <= dec_hit_c;
      lat_idx   <= dec_idx_c;
      lat_wdata <= reg_cpu_wr_data;
    end
  end

  // Bus response and interrupt
  always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_cpu_wack    <= 1'b0;
      reg_cpu_rdv     <= 1'b0;
      reg_cpu_err     <= 1'b0;
      reg_cpu_rd_data <= '0;
      irq             <= 1'b0;
    end else begin
      reg_cpu_wack <= fire_c & lat_we;
      reg_cpu_rdv  <= fire_c & ~lat_we;
      reg_cpu_err  <= fire_c & lat_err;
      irq          <= |w1c_view;
      if (fire_c && !lat_we) begin
        reg_cpu_rd_data <= lat_hit ? q_all[lat_idx] : MISS_VAL;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam acc_e ACC = acc_type(MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK), i);

    logic sel_c;
    assign sel_c = wr_commit_c && (lat_idx == IW'(i));

    if (ACC == ACC_RO) begin : g_ro
      logic unused_in;
      assign unused_in   = ^{hw_set[i*DW +: DW], sel_c};
      assign q_all[i]    = hw_ro_in[i*DW +: DW];
      assign w1c_view[i] = '0;
    end else if (ACC == ACC_W1C) begin : g_w1c
      logic [DW-1:0] q;
      logic          unused_in;
      assign unused_in = ^hw_ro_in[i*DW +: DW];
      // Hardware set wins over a simultaneous software clear.
      always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= (q & ~({DW{sel_c}} & lat_wdata)) | hw_set[i*DW +: DW];
      end
      assign q_all[i]    = q;
      assign w1c_view[i] = q;
    end else begin : g_rw
      logic [DW-1:0] q;
      logic          unused_in;
      assign unused_in = ^{hw_ro_in[i*DW +: DW], hw_set[i*DW +: DW]};
      always_ff @(posedge reg_cpu_clk or negedge rst_n) begin
        if (!rst_n)     q <= RESET_VAL;
        else if (sel_c) q <= lat_wdata;
      end
      assign q_all[i]    = q;
      assign w1c_view[i] = '0;
    end
  end

  assign reg_q = q_all;

endmodule

// File: tb/tb_reg_cpu_regbank.sv
// Scoreboard bench for reg_cpu_regbank: three instances differing only in read
// latency (1, 3, 5) share one bus and are selected by their own chip select.
module tb_reg_cpu_regbank;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 16;
  localparam int unsigned NI = 3;
  localparam int          WR_LAT = 1;
  localparam logic [NR-1:0] RO_M  = 16'h0008;
  localparam logic [NR-1:0] W1C_M = 16'h0002;
  localparam logic [31:0] RST_V = 32'hA5A5_0001;
  localparam logic [31:0] MISS  = 32'hDEAD_BEEF;
  localparam logic [31:0] RO_V  = 32'hC0DE_0003;

  function automatic int unsigned rd_lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 5);
  endfunction

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NI-1:0]     cs;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic              we;
  logic              re;
  logic [NR*DW-1:0]  hw_ro;
  logic [NR*DW-1:0]  hw_set;
  logic [DW-1:0]     rdd [NI];
  logic [NI-1:0]     wack;
  logic [NI-1:0]     rdv;
  logic [NI-1:0]     err;
  logic [NI-1:0]     irq;
  logic [NR*DW-1:0]  regq [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    reg_cpu_regbank #(
      .DW          (DW),
      .AW          (AW),
      .NUM_REGS    (NR),
      .BASE_ADDR   ('0),
      .ADDR_STRIDE (4),
      .WR_LATENCY  (WR_LAT),
      .RD_LATENCY  (rd_lat(g)),
      .RO_MASK     (RO_M),
      .W1C_MASK    (W1C_M),
      .RESET_VAL   (RST_V),
      .MISS_RD_VAL (MISS)
    ) u_dut (
      .reg_cpu_clk     (clk),
      .rst_n           (rst_n),
      .reg_cpu_cs      (cs[g]),
      .reg_cpu_addr    (addr),
      .reg_cpu_wr_data (wdata),
      .reg_cpu_we      (we),
      .reg_cpu_re      (re),
      .reg_cpu_rd_data (rdd[g]),
      .reg_cpu_wack    (wack[g]),
      .reg_cpu_rdv     (rdv[g]),
      .reg_cpu_err     (err[g]),
      .hw_ro_in        (hw_ro),
      .hw_set          (hw_set),
      .reg_q           (regq[g]),
      .irq             (irq[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    bit          is_wr;
    logic [31:0] data;
    bit          err;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] slot(input logic [NR*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Monitor: every ack pops one expectation; any ack without one is an error.
  always @(negedge clk) begin
    for (int i = 0; i < int'(NI); i++) begin
      if (wack[i] || rdv[i]) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack dut%0d: got wack=%b rdv=%b at cycle %0d, want none",
                   i, wack[i], rdv[i], cyc);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("dut%0d_inst", i), 32'(i), 32'(mon_e.inst));
          chk($sformatf("dut%0d_ack_cycle", i), 32'(cyc), 32'(mon_e.at));
          chk($sformatf("dut%0d_ack_kind", i), 32'({wack[i], rdv[i]}),
              32'(mon_e.is_wr ? 2'b10 : 2'b01));
          chk($sformatf("dut%0d_err", i), 32'(err[i]), 32'(mon_e.err));
          if (!mon_e.is_wr) chk($sformatf("dut%0d_rd_data", i), rdd[i], mon_e.data);
        end
      end else if (err[i]) begin
        checks++;
        failures++;
        $display("FAIL stray_err dut%0d: got err=1 without ack at cycle %0d, want 0", i, cyc);
      end
    end
  end

  // One bus transaction; called and returning #1 after a rising edge.
  task automatic txn(input int inst, input bit w, input bit r, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_d, input bit exp_err,
                     input int hold);
    int   lat;
    exp_t e;
    lat     = w ? WR_LAT : int'(rd_lat(inst));
    e.inst  = inst;
    e.is_wr = w;
    e.data  = exp_d;
    e.err   = exp_err;
    e.at    = cyc + 1 + lat;
    sb.push_back(e);
    cs[inst] = 1'b1;
    we       = w;
    re       = r;
    addr     = a;
    wdata    = d;
    repeat (lat + 1) @(posedge clk);
    #1;
    wdata = ~wdata;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    cs = '0;
    we = 1'b0;
    re = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    cs     = '0;
    addr   = '0;
    wdata  = '0;
    we     = 1'b0;
    re     = 1'b0;
    hw_set = '0;
    hw_ro  = {NR{RO_V}};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_rd_data", rdd[0], 32'h0);
    chk("rst_resp", 32'({wack[0], rdv[0], err[0]}), 32'h0);
    chk("rst_irq", 32'(irq[0]), 32'h0);
    chk("rst_rw_slot0", slot(regq[0], 0), RST_V);
    chk("rst_w1c_slot1", slot(regq[0], 1), 32'h0);
    chk("rst_ro_slot3", slot(regq[0], 3), RO_V);

    // Latency-1 read of reg 0
    txn(0, 1'b0, 1'b1, 32'h0, 32'h0, RST_V, 1'b0, 0);

    // Latency-3 instance: write then read reg 2
    txn(1, 1'b1, 1'b0, 32'h8, 32'h1234_5678, 32'h0, 1'b0, 0);
    chk("dut1_slot2", slot(regq[1], 2), 32'h1234_5678);
    txn(1, 1'b0, 1'b1, 32'h8, 32'h0, 32'h1234_5678, 1'b0, 0);

    // W1C reg 1: set pulse, irq one cycle later
    hw_set[32 +: 32] = 32'h5;
    @(posedge clk);
    #1;
    hw_set = '0;
    chk("w1c_set_slot1", slot(regq[0], 1), 32'h5);
    chk("irq_not_yet", 32'(irq[0]), 32'h0);
    @(posedge clk);
    #1;
    chk("irq_set", 32'(irq[0]), 32'h1);
    txn(0, 1'b1, 1'b0, 32'h4, 32'h4, 32'h0, 1'b0, 0);
    chk("w1c_clear_bit2", slot(regq[0], 1), 32'h1);
    fork
      txn(0, 1'b1, 1'b0, 32'h4, 32'h1, 32'h0, 1'b0, 0);
      begin
        @(posedge clk);
        #1;
        hw_set[32] = 1'b1;
        @(posedge clk);
        #1;
        hw_set[32] = 1'b0;
      end
    join
    chk("w1c_set_wins", slot(regq[0], 1), 32'h1);
    txn(0, 1'b1, 1'b0, 32'h4, 32'h1, 32'h0, 1'b0, 0);
    chk("w1c_clear_bit0", slot(regq[0], 1), 32'h0);
    chk("irq_cleared", 32'(irq[0]), 32'h0);

    // Read-only reg 3
    txn(0, 1'b1, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 0);
    chk("ro_slot3_kept", slot(regq[0], 3), RO_V);
    txn(0, 1'b0, 1'b1, 32'hC, 32'h0, RO_V, 1'b0, 0);

    // Decode boundaries and misses
    txn(0, 1'b0, 1'b1, 32'h3C, 32'h0, RST_V, 1'b0, 0);
    txn(0, 1'b0, 1'b1, 32'h41, 32'h0, MISS, 1'b1, 0);
    txn(0, 1'b0, 1'b1, 32'h40, 32'h0, MISS, 1'b1, 0);
    txn(0, 1'b1, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    chk("miss_wr_slot0", slot(regq[0], 0), RST_V);
    chk("miss_wr_slot15", slot(regq[0], 15), RST_V);

    // Held request after ack, then we&re collision
    txn(0, 1'b1, 1'b0, 32'h10, 32'hCAFE_0001, 32'h0, 1'b0, 10);
    chk("hold_slot4", slot(regq[0], 4), 32'hCAFE_0001);
    txn(0, 1'b1, 1'b1, 32'h14, 32'h0BAD_0005, 32'h0, 1'b1, 0);
    chk("collide_slot5", slot(regq[0], 5), 32'h0BAD_0005);

    // Latency-5 instance: reset during WAIT abandons the read
    txn(2, 1'b1, 1'b0, 32'h8, 32'h7777_0002, 32'h0, 1'b0, 0);
    txn(2, 1'b0, 1'b1, 32'h8, 32'h0, 32'h7777_0002, 1'b0, 0);
    cs[2] = 1'b1;
    re    = 1'b1;
    addr  = 32'h8;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    cs    = '0;
    re    = 1'b0;
    @(posedge clk);
    #1;
    chk("wait_rst_resp", 32'({wack[2], rdv[2], err[2]}), 32'h0);
    chk("wait_rst_rd_data", rdd[2], 32'h0);
    chk("wait_rst_irq", 32'(irq[2]), 32'h0);
    chk("wait_rst_slot2", slot(regq[2], 2), RST_V);
    chk("wait_rst_slot1", slot(regq[2], 1), 32'h0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    txn(2, 1'b0, 1'b1, 32'h8, 32'h0, RST_V, 1'b0, 0);

    repeat (10) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
